// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: word size, default RAM depth,
// funct3 encodings, FSM state encoding, request record and funct3 legality check.
package mem_access_unit_pkg;

    localparam int WORDSIZE    = 32;
    localparam int ROM_COL_MAX = 64;

    // funct3 encodings (loads use all five; stores use B/H/W only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RDW      = 3'd2,
        WR       = 3'd3,
        RESP_ERR = 3'd4
    } state_t;

    typedef struct packed {
        logic                we;
        logic [2:0]          funct3;
        logic [WORDSIZE-1:0] addr;
        logic [WORDSIZE-1:0] wdata;
    } req_t;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: combinational lane select with sign/zero extension for loads, and
// byte/halfword merge into a fetched word for sub-word stores.
// Ports:
//   funct3    - access size/sign encoding
//   lane      - byte offset within the word (addr[1:0])
//   rdata     - word read from RAM
//   wdata     - store data (low byte/halfword used for SB/SH)
//   load_data - extended load result
//   merged    - rdata with the store byte/halfword inserted (wdata for SW)
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          lane,
    input  logic [WORDSIZE-1:0] rdata,
    input  logic [WORDSIZE-1:0] wdata,
    output logic [WORDSIZE-1:0] load_data,
    output logic [WORDSIZE-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{lane, 3'b000} +: 8];
        half_sel  = rdata[{lane[1], 4'b0000} +: 16];
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merged = wdata;
        if (funct3 == F3_B) begin
            merged = rdata;
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3 == F3_H) begin
            merged = rdata;
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit in front of a word RAM with
// registered reads. Sub-word stores are done as read-modify-write.
// Optional macro MISALIGN_TRAP_EN: misaligned halfword/word accesses are rejected
// as errors; when undefined they are silently aligned down.
// Ports:
//   CLK, reset                       - clock, async active-high reset
//   req_valid/req_ready              - request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                        - request fields
//   resp_valid, resp_rdata, resp_err - one-cycle response, no backpressure
//   mem_addr, mem_write_data,
//   mem_memread, mem_memwrite        - RAM side (word index, strobes)
//   mem_read_data                    - RAM data, valid the cycle after mem_memread
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int RAM_WORDS = ROM_COL_MAX
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [WORDSIZE-1:0] req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORDSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_write_data,
    output logic                mem_memread,
    output logic                mem_memwrite,
    input  logic [WORDSIZE-1:0] mem_read_data
);

    state_t              state, next_state;
    req_t                req_q;
    logic                accept;
    logic                is_half, is_word, misalign, range_err, req_err;
    logic [WORDSIZE-1:0] addr_al;
    logic [WORDSIZE-1:0] q_idx;
    logic [WORDSIZE-1:0] load_data, merged;

    assign accept    = req_valid && (state == IDLE);
    assign range_err = {2'b00, req_addr[WORDSIZE-1:2]} >= WORDSIZE'(RAM_WORDS);
    assign q_idx     = {2'b00, req_q.addr[WORDSIZE-1:2]};

    // Halfword covers LH/LHU/SH, word covers LW/SW.
    always_comb begin
        is_half = (req_funct3[1:0] == 2'b01);
        is_word = (req_funct3 == F3_W);
`ifdef MISALIGN_TRAP_EN
        misalign = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
        addr_al  = req_addr;
`else
        misalign = 1'b0;
        addr_al  = req_addr;
        if (is_half) addr_al[0]   = 1'b0;
        if (is_word) addr_al[1:0] = 2'b00;
`endif
        req_err = !funct3_legal(req_we, req_funct3) || range_err || misalign;
    end

    load_extend u_ext (
        .funct3    (req_q.funct3),
        .lane      (req_q.addr[1:0]),
        .rdata     (mem_read_data),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_q.we     <= req_we;
                req_q.funct3 <= req_funct3;
                req_q.addr   <= addr_al;
                req_q.wdata  <= req_wdata;
            end else if (state == RDW && req_q.we) begin
                // wdata becomes the full merged word written in WR
                req_q.wdata <= merged;
            end
        end
    end

    always_comb begin
        next_state     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_err       = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                if (accept) begin
                    if (req_err)
                        next_state = RESP_ERR;
                    else if (req_we && req_funct3 == F3_W)
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD: begin
                mem_memread = 1'b1;
                mem_addr    = q_idx;
                next_state  = RDW;
            end
            RDW: begin
                if (req_q.we) begin
                    next_state = WR;
                end else begin
                    resp_valid = 1'b1;
                    resp_rdata = load_data;
                    next_state = IDLE;
                end
            end
            WR: begin
                mem_memwrite   = 1'b1;
                mem_addr       = q_idx;
                mem_write_data = req_q.wdata;
                resp_valid     = 1'b1;
                next_state     = IDLE;
            end
            RESP_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
